floor_request_scheduler: RTL and testbench
==========================================

// Module: floor_request_scheduler
// PURPOSE
//   Parametrised successor to the combinational floor-request encoder.
//   - Latches hall/car call requests for NUM_FLOORS floors and clears each one when it is served.
//   - Picks the next target floor with an up/down sweep (SCAN) FSM.
//   - Sits between the call-button inputs and the car motion controller.
// PARAMETERS
//   NUM_FLOORS  11  number of floors/request lines (2..64)
//   FLOOR_W      4  floor index width; must be >= $clog2(NUM_FLOORS)
// PORTS
//   clk          in   1           system clock, rising edge
//   rst_n        in   1           asynchronous active-low reset
//   req_i        in   NUM_FLOORS  call requests, level or pulse; bit k = floor k
//   cur_floor_i  in   FLOOR_W     floor the car is at or passing
//   arrive_i     in   1           1-cycle pulse: car stopped at cur_floor_i, doors open
//   pending_o    out  NUM_FLOORS  latched outstanding requests
//   target_o     out  FLOOR_W     next floor to serve
//   target_vld_o out  1           target_o is meaningful
//   dir_o        out  2           00 idle, 01 up, 10 down (11 never driven)
// BEHAVIOUR
//   Reset (async assert, sync release):
//     pending_o=0, FSM=IDLE, dir_o=00, target_o=0, target_vld_o=0.
//   Request latch, every cycle:
//     pending <= (pending | req_i) & ~clr.
//     clr = onehot(cur_floor_i) when arrive_i is 1, else 0.
//     If a request and a clear hit the same floor in one cycle, the clear wins:
//     the doors are open, so the request counts as served.
//   Derived masks, from the registered pending and the current cur_floor_i:
//     above = pending bits > cur_floor_i; below = pending bits < cur_floor_i.
//   FSM states: IDLE, UP, DOWN.
//     IDLE -> UP   if above != 0. Above has priority when both above and below are nonzero.
//     IDLE -> DOWN if above == 0 and below != 0.
//     UP   -> stays UP while above != 0.
//     UP   -> DOWN when above == 0 and below != 0; UP -> IDLE when both are 0.
//     DOWN -> mirror of UP, with above/below swapped.
//   Target, registered from the next-state value:
//     UP: lowest set bit of above. DOWN: highest set bit of below.
//     IDLE with only pending[cur] set: target_o = cur_floor_i, target_vld_o = 1.
//     Nothing pending: target_vld_o = 0 and target_o holds its last value.
//   Latency: 1 clk from the req_i/arrive_i edge to pending_o;
//     1 further clk to dir_o/target_o.
//   dir_o is a direct encoding of the FSM state.
//   Out-of-range cur_floor_i (>= NUM_FLOORS):
//     arrive_i is ignored and nothing is cleared; FSM is forced to IDLE;
//     target_vld_o = 0; req_i is still latched.
//   Bits of req_i above NUM_FLOORS-1 do not exist; there is no wrap-around.
// CONFIGURATION
//   SERVICE_LOCK_EN defined:
//     Adds input lock_i[NUM_FLOORS] (1 = floor locked out).
//     Locked floors are never latched. Already-pending locked bits are purged on the next clk.
//     Locked floors are excluded from above/below.
//   SERVICE_LOCK_EN undefined: no lock_i port; all floors are eligible.
// STRUCTURE
//   Package elevator_pkg:
//     dir_e enum {DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10};
//     sched_state_e {IDLE, UP, DOWN};
//     DEF_NUM_FLOORS = 11.
//   Sub-module floor_prio_enc:
//     Parametrised combinational find-first with a LOW_FIRST mode bit.
//     Outputs idx and vld.
//     Instantiated twice: lowest set bit of above, highest set bit of below.
//   The top level holds the pending register, the FSM and the output registers.
// TESTING (NUM_FLOORS=11)
//   1. Idle, cur=3, req_i bits 7 and 1 pulsed -> pending=0x082;
//      next clk dir_o=01, target_o=7.
//      Then cur=7 with arrive -> bit 7 clears; dir_o=10, target_o=1.
//   2. cur=2, pending bits 5 and 9, UP -> target_o=5.
//      Arrive at 5 -> target_o=9, dir stays 01.
//   3. cur=4, req_i bit 4 in the same cycle as arrive_i -> pending bit 4 stays 0;
//      dir_o=00, target_vld_o=0.
//   4. Only bit 6 pending, cur=6, no arrive -> IDLE, target_o=6, target_vld_o=1.
//   5. cur_floor_i=12 with arrive_i -> no bit cleared, dir_o=00, target_vld_o=0.
//      rst_n low mid-sweep -> all outputs 0 immediately.
//   6. SERVICE_LOCK_EN build, lock_i bit 8 set, pending bit 8 -> bit 8 purged next clk;
//      req_i bit 8 ignored; target skips floor 8.

Source files
------------

// File: rtl/elevator_pkg.sv
// ----------------------------------------------------------------------------
// elevator_pkg
//   Shared types and constants for the elevator request scheduler.
//   - dir_e         : encoding of the travel direction seen by the motion
//                     controller (00 idle, 01 up, 10 down).
//   - sched_state_e : SCAN sweep FSM states, encoded so that each state's
//                     bits equal its dir_e value.
//   - DEF_NUM_FLOORS: default building height.
//   - to_dir()      : maps an FSM state onto the direction encoding.
// Optional feature macro used elsewhere in this slice: SERVICE_LOCK_EN.
// ----------------------------------------------------------------------------
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } sched_state_e;

  localparam int DEF_NUM_FLOORS = 11;

  function automatic dir_e to_dir(input sched_state_e s);
    case (s)
      UP:      return DIR_UP;
      DOWN:    return DIR_DOWN;
      default: return DIR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/floor_prio_enc.sv
// ----------------------------------------------------------------------------
// floor_prio_enc
//   Combinational find-first encoder over a request vector.
//   LOW_FIRST = 1 returns the lowest set bit; LOW_FIRST = 0 returns the
//   highest set bit.
// Parameters:
//   WIDTH     number of request lines
//   IDX_W     width of the returned index
//   LOW_FIRST search direction select
// Ports:
//   vec   in   WIDTH  request vector
//   idx   out  IDX_W  index of the selected bit (0 when vld is 0)
//   vld   out  1      at least one bit of vec is set
// ----------------------------------------------------------------------------
module floor_prio_enc #(
  parameter int WIDTH     = 11,
  parameter int IDX_W     = 4,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // The winning bit is the one visited last, so the scan runs towards the
  // preferred end of the vector.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    if (LOW_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx = IDX_W'(i);
          vld = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          idx = IDX_W'(i);
          vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/floor_request_scheduler.sv
// ----------------------------------------------------------------------------
// floor_request_scheduler
//   Latches hall/car calls, clears them as the car is served, and selects the
//   next target floor with an up/down (SCAN) sweep FSM.
// Parameters:
//   NUM_FLOORS   number of floors / request lines (2..64)
//   FLOOR_W      floor index width, >= $clog2(NUM_FLOORS)
// Ports:
//   clk          in   1           rising-edge clock
//   rst_n        in   1           asynchronous active-low reset
//   req_i        in   NUM_FLOORS  call requests (level or pulse)
//   lock_i       in   NUM_FLOORS  floor lock-out, only with SERVICE_LOCK_EN
//   cur_floor_i  in   FLOOR_W     floor the car is at or passing
//   arrive_i     in   1           car stopped at cur_floor_i, doors open
//   pending_o    out  NUM_FLOORS  latched outstanding requests
//   target_o     out  FLOOR_W     next floor to serve
//   target_vld_o out  1           target_o is meaningful
//   dir_o        out  2           00 idle, 01 up, 10 down
// Configuration macro: SERVICE_LOCK_EN adds lock_i; locked floors are never
//   latched, are purged from pending, and are ignored by the sweep.
// ----------------------------------------------------------------------------
module floor_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req_i,
`ifdef SERVICE_LOCK_EN
  input  logic [NUM_FLOORS-1:0] lock_i,
`endif
  input  logic [FLOOR_W-1:0]    cur_floor_i,
  input  logic                  arrive_i,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic [FLOOR_W-1:0]    target_o,
  output logic                  target_vld_o,
  output logic [1:0]            dir_o
);

  logic [NUM_FLOORS-1:0] pending_q;
  logic [NUM_FLOORS-1:0] eligible;
  logic [NUM_FLOORS-1:0] cur_onehot;
  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] above;
  logic [NUM_FLOORS-1:0] below;
  logic                  in_range;
  logic                  cur_hit;

  logic [FLOOR_W-1:0]    up_idx;
  logic [FLOOR_W-1:0]    down_idx;
  logic                  up_vld;
  logic                  down_vld;

  sched_state_e          state_q;
  sched_state_e          state_d;
  logic [FLOOR_W-1:0]    target_q;
  logic [FLOOR_W-1:0]    target_d;
  logic                  vld_q;
  logic                  vld_d;

  assign in_range = (int'(cur_floor_i) < NUM_FLOORS);

  // Locked floors drop out of the sweep immediately, even before the
  // register purge takes effect on the next edge.
`ifdef SERVICE_LOCK_EN
  assign eligible = pending_q & ~lock_i;
`else
  assign eligible = pending_q;
`endif

  // An out-of-range floor produces an all-zero one-hot, which is what makes
  // arrive_i harmless there.
  always_comb begin
    cur_onehot = '0;
    above      = '0;
    below      = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      cur_onehot[k] = in_range && (k == int'(cur_floor_i));
      above[k]      = eligible[k] && (k > int'(cur_floor_i));
      below[k]      = eligible[k] && (k < int'(cur_floor_i));
    end
  end

  assign clr     = arrive_i ? cur_onehot : '0;
  assign cur_hit = |(eligible & cur_onehot);

  floor_prio_enc #(
    .WIDTH     (NUM_FLOORS),
    .IDX_W     (FLOOR_W),
    .LOW_FIRST (1'b1)
  ) u_enc_above (
    .vec (above),
    .idx (up_idx),
    .vld (up_vld)
  );

  floor_prio_enc #(
    .WIDTH     (NUM_FLOORS),
    .IDX_W     (FLOOR_W),
    .LOW_FIRST (1'b0)
  ) u_enc_below (
    .vec (below),
    .idx (down_idx),
    .vld (down_vld)
  );

  // Request latch: the clear is applied after the OR, so a call pressed while
  // the doors are open at that floor counts as already served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
`ifdef SERVICE_LOCK_EN
      pending_q <= (pending_q | req_i) & ~clr & ~lock_i;
`else
      pending_q <= (pending_q | req_i) & ~clr;
`endif
    end
  end

  // SCAN next-state: keep sweeping while work remains ahead, reverse when it
  // only remains behind. Leaving IDLE prefers going up.
  always_comb begin
    state_d = state_q;
    if (!in_range) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = up_vld   ? UP   : (down_vld ? DOWN : IDLE);
        UP:      state_d = up_vld   ? UP   : (down_vld ? DOWN : IDLE);
        DOWN:    state_d = down_vld ? DOWN : (up_vld   ? UP   : IDLE);
        default: state_d = IDLE;
      endcase
    end
  end

  // Target follows the state being entered; with nothing to serve the last
  // target is held so the motion controller never sees a spurious floor.
  always_comb begin
    target_d = target_q;
    vld_d    = 1'b0;
    if (in_range) begin
      case (state_d)
        UP: begin
          target_d = up_idx;
          vld_d    = 1'b1;
        end
        DOWN: begin
          target_d = down_idx;
          vld_d    = 1'b1;
        end
        default: begin
          if (cur_hit) begin
            target_d = cur_floor_i;
            vld_d    = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      vld_q    <= vld_d;
    end
  end

  assign pending_o    = pending_q;
  assign target_o     = target_q;
  assign target_vld_o = vld_q;
  assign dir_o        = to_dir(state_q);

endmodule

// File: tb/tb_floor_request_scheduler.sv
// ----------------------------------------------------------------------------
// tb_floor_request_scheduler
//   Directed test of the floor request scheduler with NUM_FLOORS = 11.
//   Honours SERVICE_LOCK_EN to connect lock_i and run the lock-out scenario.
// ----------------------------------------------------------------------------
module tb_floor_request_scheduler;

  localparam int NF = 11;
  localparam int FW = 4;

  logic          clk;
  logic          rst_n;
  logic [NF-1:0] req;
  logic [NF-1:0] lock;
  logic [FW-1:0] cur_floor;
  logic          arrive;
  logic [NF-1:0] pending;
  logic [FW-1:0] target;
  logic          target_vld;
  logic [1:0]    dir;

  int n_compared;
  int n_mismatched;

  floor_request_scheduler #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
`ifdef SERVICE_LOCK_EN
    .lock_i       (lock),
`endif
    .cur_floor_i  (cur_floor),
    .arrive_i     (arrive),
    .pending_o    (pending),
    .target_o     (target),
    .target_vld_o (target_vld),
    .dir_o        (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle, so inputs change and outputs are
  // sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = '0;
    lock      = '0;
    cur_floor = '0;
    arrive    = 1'b0;
    #12;
    n_compared++;
    if (pending !== 11'h000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_pending: got %h want %h", pending, 11'h000);
    end
    n_compared++;
    if ({dir, target_vld, target} !== 7'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got dir=%b vld=%b tgt=%0d want all 0", dir, target_vld, target);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sweep_reverse();
    cur_floor = 4'd3;
    req       = 11'h082;
    tick();
    req = '0;
    n_compared++;
    if (pending !== 11'h082 || dir !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL sweep_latch: got pend=%h dir=%b want pend=082 dir=00", pending, dir);
    end
    tick();
    n_compared++;
    if (dir !== 2'b01 || target !== 4'd7 || target_vld !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL sweep_up: got dir=%b tgt=%0d vld=%b want 01/7/1", dir, target, target_vld);
    end
    cur_floor = 4'd7;
    arrive    = 1'b1;
    tick();
    arrive = 1'b0;
    n_compared++;
    if (pending !== 11'h002 || dir !== 2'b10 || target !== 4'd1) begin
      n_mismatched++;
      $display("[TB] FAIL sweep_reverse: got pend=%h dir=%b tgt=%0d want 002/10/1", pending, dir, target);
    end
    cur_floor = 4'd1;
    arrive    = 1'b1;
    tick();
    arrive = 1'b0;
    tick();
    n_compared++;
    if (pending !== 11'h000 || dir !== 2'b00 || target_vld !== 1'b0 || target !== 4'd1) begin
      n_mismatched++;
      $display("[TB] FAIL idle_hold: got pend=%h dir=%b vld=%b tgt=%0d want 000/00/0/1", pending, dir, target_vld, target);
    end
  endtask

  task automatic test_continue_up();
    cur_floor = 4'd2;
    req       = 11'h220;
    tick();
    req = '0;
    tick();
    n_compared++;
    if (dir !== 2'b01 || target !== 4'd5) begin
      n_mismatched++;
      $display("[TB] FAIL up_first: got dir=%b tgt=%0d want 01/5", dir, target);
    end
    cur_floor = 4'd5;
    arrive    = 1'b1;
    tick();
    arrive = 1'b0;
    n_compared++;
    if (dir !== 2'b01 || target !== 4'd9 || pending !== 11'h200) begin
      n_mismatched++;
      $display("[TB] FAIL up_next: got dir=%b tgt=%0d pend=%h want 01/9/200", dir, target, pending);
    end
    cur_floor = 4'd9;
    arrive    = 1'b1;
    tick();
    arrive = 1'b0;
    tick();
    n_compared++;
    if (pending !== 11'h000 || dir !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL up_done: got pend=%h dir=%b want 000/00", pending, dir);
    end
  endtask

  task automatic test_req_during_arrive();
    cur_floor = 4'd4;
    req       = 11'h010;
    arrive    = 1'b1;
    tick();
    req    = '0;
    arrive = 1'b0;
    n_compared++;
    if (pending !== 11'h000) begin
      n_mismatched++;
      $display("[TB] FAIL clear_wins: got pend=%h want 000", pending);
    end
    tick();
    n_compared++;
    if (dir !== 2'b00 || target_vld !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL clear_wins_idle: got dir=%b vld=%b want 00/0", dir, target_vld);
    end
  endtask

  task automatic test_idle_at_floor();
    cur_floor = 4'd6;
    req       = 11'h040;
    tick();
    req = '0;
    tick();
    n_compared++;
    if (dir !== 2'b00 || target !== 4'd6 || target_vld !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL idle_here: got dir=%b tgt=%0d vld=%b want 00/6/1", dir, target, target_vld);
    end
    cur_floor = 4'd6;
    arrive    = 1'b1;
    tick();
    arrive = 1'b0;
    tick();
    n_compared++;
    if (pending !== 11'h000 || target_vld !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_here_served: got pend=%h vld=%b want 000/0", pending, target_vld);
    end
  endtask

  task automatic test_out_of_range_and_reset();
    cur_floor = 4'd3;
    req       = 11'h004;
    tick();
    req = '0;
    tick();
    n_compared++;
    if (dir !== 2'b10 || target !== 4'd2) begin
      n_mismatched++;
      $display("[TB] FAIL oor_setup: got dir=%b tgt=%0d want 10/2", dir, target);
    end
    cur_floor = 4'd12;
    arrive    = 1'b1;
    tick();
    arrive = 1'b0;
    n_compared++;
    if (pending !== 11'h004 || dir !== 2'b00 || target_vld !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL oor_ignore: got pend=%h dir=%b vld=%b want 004/00/0", pending, dir, target_vld);
    end
    req = 11'h200;
    tick();
    req = '0;
    n_compared++;
    if (pending !== 11'h204 || dir !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL oor_latch: got pend=%h dir=%b want 204/00", pending, dir);
    end
    cur_floor = 4'd3;
    tick();
    n_compared++;
    if (dir !== 2'b01 || target !== 4'd9 || target_vld !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL oor_resume: got dir=%b tgt=%0d vld=%b want 01/9/1", dir, target, target_vld);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (pending !== 11'h000 || dir !== 2'b00 || target !== 4'd0 || target_vld !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got pend=%h dir=%b tgt=%0d vld=%b want all 0", pending, dir, target, target_vld);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef SERVICE_LOCK_EN
  task automatic test_lock();
    cur_floor = 4'd0;
    req       = 11'h500;
    tick();
    req = '0;
    n_compared++;
    if (pending !== 11'h500) begin
      n_mismatched++;
      $display("[TB] FAIL lock_setup: got pend=%h want 500", pending);
    end
    lock = 11'h100;
    tick();
    n_compared++;
    if (pending !== 11'h400 || target !== 4'd10 || dir !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL lock_purge: got pend=%h tgt=%0d dir=%b want 400/10/01", pending, target, dir);
    end
    req = 11'h100;
    tick();
    req = '0;
    n_compared++;
    if (pending !== 11'h400) begin
      n_mismatched++;
      $display("[TB] FAIL lock_ignore_req: got pend=%h want 400", pending);
    end
    lock = '0;
  endtask
`endif

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_sweep_reverse();
    test_continue_up();
    test_req_during_arrive();
    test_idle_at_floor();
    test_out_of_range_and_reset();
`ifdef SERVICE_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
